// File: rtl/wash_pkg.sv
// Shared definitions for the wash controller blocks: phase state encoding,
// divider tick period and the default tick watchdog limit.
package wash_pkg;

    localparam int DIV_TICK_PERIOD = 100_000_001;
    localparam int WDOG_CYCLES_DEF = 100_000_010;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_FAULT = 2'd3;

    // A phase is in progress while counting or frozen; FAULT is not busy.
    function automatic logic state_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/phase_timer_tick_watchdog.sv
// Counts clk cycles since the last divider tick while enabled and flags the
// cycle in which the limit is reached without a tick arriving.
module tick_watchdog
    import wash_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    parameter int WDOG_W      = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] cnt;

    // Disabled means held at zero, so re-entering RUN always starts fresh.
    always_ff @(posedge clk) begin
        if (rst || clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    assign expired = en && !tick && (cnt == LAST);

endmodule

// File: rtl/phase_timer.sv
// Times one wash phase in divider ticks: load, count down, pause/resume,
// completion pulse, and a watchdog fault when the tick stream stops.
module phase_timer
    import wash_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    parameter int WDOG_W      = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [CNT_W-1:0] dur,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             tick_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state;
    state_t state_nxt;
    logic   wd_expired;
    logic   wd_en;
    logic   wd_clr;
    logic   last_tick;
    logic   leave_run;

    assign last_tick = (state == ST_RUN) && tick && (remaining == ONE);

    // Leaving RUN is derived from inputs only, never from the watchdog itself.
    assign leave_run = (state == ST_RUN) && (last_tick || pause);
    assign wd_en     = (state == ST_RUN);
    assign wd_clr    = abort || (start && (state != ST_RUN)) || leave_run;

    tick_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES),
        .WDOG_W     (WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .tick   (tick),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (dur != '0)) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (last_tick) state_nxt = ST_IDLE;
                    else if (wd_expired) state_nxt = ST_FAULT;
                    else if (pause) state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_FAULT;
            endcase
        end
    end

    // Status flags decode the state register directly, so they carry no input path.
    always_comb begin
        busy     = state_busy(state);
        paused   = (state == ST_PAUSE);
        tick_err = (state == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (dur != '0) remaining <= dur;
                            else done <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (tick && (remaining != '0)) begin
                            remaining <= remaining - ONE;
                            if (remaining == ONE) done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with a short watchdog and a tick every 10 clks.
module tb_phase_timer;

    localparam int CNT_W = 8;
    localparam int WDOG  = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             start;
    logic [CNT_W-1:0] dur;
    logic             pause;
    logic             abort;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;
    logic             done;
    logic             tick_err;

    int n_chk = 0;
    int n_err = 0;

    phase_timer #(
        .CNT_W      (CNT_W),
        .WDOG_CYCLES(WDOG),
        .WDOG_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .dur      (dur),
        .pause    (pause),
        .abort    (abort),
        .remaining(remaining),
        .busy     (busy),
        .paused   (paused),
        .done     (done),
        .tick_err (tick_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // 9 quiet clks then one clk with tick high: one tick every 10 clks.
    task automatic tick_period();
        idle(9);
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] d);
        dur   = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b1; dur = 8'd5; pause = 1'b0; abort = 1'b0;

        // 1: reset dominates a held start
        idle(3);
        rst = 1'b0; start = 1'b0;
        chk("rst_rem", remaining, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", tick_err, 0);
        step();
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_paused", paused, 0);

        // 2: plain countdown of 3
        do_start(8'd3);
        chk("t2_busy", busy, 1);
        chk("t2_rem3", remaining, 3);
        tick_period();
        chk("t2_rem2", remaining, 2);
        tick_period();
        chk("t2_rem1", remaining, 1);
        chk("t2_nodone", done, 0);
        tick_period();
        chk("t2_rem0", remaining, 0);
        chk("t2_done", done, 1);
        chk("t2_busy0", busy, 0);
        step();
        chk("t2_done_1cyc", done, 0);

        // 3: pause holds through ticks, resume finishes
        do_start(8'd4);
        tick_period();
        chk("t3_rem3", remaining, 3);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("t3_paused", paused, 1);
        for (int i = 0; i < 4; i++) tick_period();
        chk("t3_hold_rem", remaining, 3);
        chk("t3_hold_paused", paused, 1);
        chk("t3_hold_busy", busy, 1);
        do_start(8'd0);
        chk("t3_resumed", paused, 0);
        chk("t3_resume_rem", remaining, 3);
        tick_period();
        tick_period();
        chk("t3_rem1", remaining, 1);
        tick_period();
        chk("t3_done", done, 1);
        chk("t3_rem0", remaining, 0);

        // 4: zero duration pulses done without busy; start in RUN ignored
        step();
        do_start(8'd0);
        chk("t4_done0", done, 1);
        chk("t4_busy0", busy, 0);
        step();
        chk("t4_done_clr", done, 0);
        do_start(8'd5);
        chk("t4_rem5", remaining, 5);
        do_start(8'd9);
        chk("t4_ign_rem", remaining, 5);
        tick_period();
        chk("t4_rem4", remaining, 4);
        do_abort();
        chk("t4_abort_rem", remaining, 0);
        chk("t4_abort_busy", busy, 0);

        // 5: ticks stop, watchdog faults 12 clks after the last tick
        do_start(8'd6);
        tick_period();
        tick_period();
        chk("t5_rem4", remaining, 4);
        idle(11);
        chk("t5_not_yet", tick_err, 0);
        chk("t5_busy_pre", busy, 1);
        step();
        chk("t5_err", tick_err, 1);
        chk("t5_rem_hold", remaining, 4);
        chk("t5_busy0", busy, 0);
        do_start(8'd7);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t5_err_sticky", tick_err, 1);
        chk("t5_ign_rem", remaining, 4);
        do_abort();
        chk("t5_abort_err", tick_err, 0);
        chk("t5_abort_rem", remaining, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);

        // 6a: abort beats the final tick
        do_start(8'd2);
        tick_period();
        chk("t6_rem1", remaining, 1);
        idle(9);
        tick = 1'b1; abort = 1'b1;
        step();
        tick = 1'b0; abort = 1'b0;
        chk("t6_nodone", done, 0);
        chk("t6_rem0", remaining, 0);
        chk("t6_idle", busy, 0);
        step();
        chk("t6_nodone_late", done, 0);

        // 6b: pause with a tick applies the decrement then freezes
        do_start(8'd3);
        tick_period();
        chk("t6_rem2", remaining, 2);
        idle(9);
        tick = 1'b1; pause = 1'b1;
        step();
        tick = 1'b0; pause = 1'b0;
        chk("t6_pt_rem", remaining, 1);
        chk("t6_pt_paused", paused, 1);
        do_abort();
        chk("t6_end_paused", paused, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
